// File: rtl/idct_pass_engine.sv
// rtl/idct_pass_engine.sv - single-pass IDCT matrix engine (ROW: S'xC, COL: C^TxT with 8-bit clip)
module idct_pass_engine #(
    parameter int N         = 8,
    parameter int NUM_MULT  = 2,
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 12,
    parameter int SHIFT_ROW = 8,
    parameter int SHIFT_COL = 16,
    localparam int ADDR_W   = $clog2(N*N),
    localparam int CADDR_W  = $clog2(N*N/NUM_MULT),
    localparam int ACC_W    = DATA_W + COEF_W + $clog2(N)
) (
    input  logic                       CLOCK_50_I,
    input  logic                       Resetn,
    input  logic                       start,
    input  logic                       pass_mode,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          src_addr,
    input  logic [DATA_W-1:0]          src_rdata,
    output logic [CADDR_W-1:0]         coef_addr,
    input  logic [NUM_MULT*COEF_W-1:0] coef_rdata,
    output logic [ADDR_W-1:0]          dst_addr,
    output logic [DATA_W-1:0]          dst_wdata,
    output logic                       dst_we
);
    localparam int LW   = $clog2(N);
    localparam int CW   = $clog2(N+1);
    localparam int MW   = (NUM_MULT > 1) ? $clog2(NUM_MULT) : 1;
    localparam int GPR  = N / NUM_MULT;
    localparam int NGRP = N * N / NUM_MULT;
    localparam int PW   = DATA_W + COEF_W;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t                    state;
    logic                      mode;
    logic [CADDR_W-1:0]        grp;
    logic [CW-1:0]             cyc;
    logic [MW-1:0]             wm;
    logic signed [ACC_W-1:0]   acc      [NUM_MULT];
    logic signed [ACC_W-1:0]   acc_next [NUM_MULT];
    logic signed [PW-1:0]      prod     [NUM_MULT];

    function automatic logic [LW-1:0] outer_of(input logic [CADDR_W-1:0] gr);
        return LW'(gr / CADDR_W'(GPR));
    endfunction

    function automatic logic [ADDR_W-1:0] src_at(input logic md, input logic [CADDR_W-1:0] gr,
                                                 input logic [LW-1:0] k);
        logic [LW-1:0] o;
        o = outer_of(gr);
        return md ? {k, o} : {o, k};
    endfunction

    function automatic logic [CADDR_W-1:0] coef_at(input logic [CADDR_W-1:0] gr, input logic [LW-1:0] k);
        return CADDR_W'(k) * CADDR_W'(GPR) + gr % CADDR_W'(GPR);
    endfunction

    // ROW writes row outer, cols j0+m; COL writes col outer, rows i0+m
    function automatic logic [ADDR_W-1:0] dst_at(input logic md, input logic [CADDR_W-1:0] gr,
                                                 input logic [MW-1:0] lm);
        logic [LW-1:0] o;
        logic [LW-1:0] lane;
        o    = outer_of(gr);
        lane = LW'(int'(gr % CADDR_W'(GPR)) * NUM_MULT + int'(lm));
        return md ? {lane, o} : {o, lane};
    endfunction

    function automatic logic [DATA_W-1:0] wdata_of(input logic md, input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        if (!md) begin
            sh = a >>> SHIFT_ROW;
            return sh[DATA_W-1:0];
        end
        sh = a >>> SHIFT_COL;
        if (sh[ACC_W-1])
            return '0;
        if (sh > ACC_W'(255))
            return DATA_W'(255);
        return {{(DATA_W-8){1'b0}}, sh[7:0]};
    endfunction

    always_comb begin
        for (int m = 0; m < NUM_MULT; m++) begin
            prod[m]     = PW'(signed'(src_rdata)) * PW'(signed'(coef_rdata[m*COEF_W +: COEF_W]));
            acc_next[m] = acc[m] + ACC_W'(prod[m]);
        end
    end

    logic [MW-1:0]      wm_n;
    logic [CADDR_W-1:0] grp_n;
    logic [LW-1:0]      k_n;
    assign wm_n  = wm + 1'b1;
    assign grp_n = grp + 1'b1;
    assign k_n   = LW'(cyc + 1'b1);

    always_ff @(posedge CLOCK_50_I) begin
        if (!Resetn) begin
            state     <= IDLE;
            mode      <= 1'b0;
            grp       <= '0;
            cyc       <= '0;
            wm        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            src_addr  <= '0;
            coef_addr <= '0;
            dst_addr  <= '0;
            dst_wdata <= '0;
            dst_we    <= 1'b0;
            for (int m = 0; m < NUM_MULT; m++) acc[m] <= '0;
        end else begin
            done   <= 1'b0;
            dst_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode      <= pass_mode;
                        grp       <= '0;
                        cyc       <= '0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                        src_addr  <= src_at(pass_mode, '0, '0);
                        coef_addr <= coef_at('0, '0);
                        for (int m = 0; m < NUM_MULT; m++) acc[m] <= '0;
                    end
                end
                FETCH: begin
                    // read data lags the address by one cycle, so cycle c accumulates k=c-1
                    if (cyc != '0)
                        for (int m = 0; m < NUM_MULT; m++) acc[m] <= acc_next[m];
                    if (cyc == CW'(N)) begin
                        state     <= WRITE;
                        wm        <= '0;
                        dst_we    <= 1'b1;
                        dst_addr  <= dst_at(mode, grp, '0);
                        dst_wdata <= wdata_of(mode, acc_next[0]);
                    end else begin
                        cyc <= cyc + 1'b1;
                        if (int'(cyc) + 1 < N) begin
                            src_addr  <= src_at(mode, grp, k_n);
                            coef_addr <= coef_at(grp, k_n);
                        end
                    end
                end
                WRITE: begin
                    if (wm == MW'(NUM_MULT-1)) begin
                        if (int'(grp) == NGRP-1) begin
                            state <= DONE;
                        end else begin
                            grp       <= grp_n;
                            cyc       <= '0;
                            state     <= FETCH;
                            src_addr  <= src_at(mode, grp_n, '0);
                            coef_addr <= coef_at(grp_n, '0);
                            for (int m = 0; m < NUM_MULT; m++) acc[m] <= '0;
                        end
                    end else begin
                        wm        <= wm_n;
                        dst_we    <= 1'b1;
                        dst_addr  <= dst_at(mode, grp, wm_n);
                        dst_wdata <= wdata_of(mode, acc[wm_n]);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
